cpx_dest_arb: RTL
=================

// Module: cpx_dest_arb
// PURPOSE
//  Per-destination CPX arbiter stage fed by the p-buffer row: consumes buffered,
//  positive-polarity request/atomic strobes from scache0-3 and IO for one SPARC
//  core, tracks each source's queued packets, and issues one-hot registered grants.
//  Grants return upstream through the p-buffer grant chain; the core's data-ready
//  strobe gates issue. Round-robin fair; atomic pairs are granted back-to-back.
// PARAMETERS
//  NSRC    5  number of sources; bits 0..NSRC-2 = scache0.., bit NSRC-1 = IO
//  QDEPTH  2  per-source queue depth tracked (legal 2..3; atomic pairs need >=2)
// PORTS
//  rclk             in   1     core clock, all state on rising edge
//  arst_l           in   1     asynchronous active-low reset
//  src_req_cq       in   NSRC  one-cycle strobe: source enqueued one packet
//  src_atom_cq      in   NSRC  qualifies src_req_cq: packet is first half of atomic pair
//  spc_data_rdy_cx  in   1     destination can accept a packet this cycle
//  grant_ca         out  NSRC  registered one-hot grant (at most one bit set)
//  arb_lock_ca      out  1     registered: arbiter locked on 2nd half of atomic pair
//  q_ovf_err        out  1     sticky: request received with source queue full
// BEHAVIOUR
//  - Reset (async assert, sync deassert by caller): grant_ca=0, arb_lock_ca=0,
//    q_ovf_err=0, all counts=0, atom flags=0, RR pointer=0 (scache0 highest).
//  - Per source: cnt[$clog2(QDEPTH+1)-1:0]; cnt_nxt = cnt + req - grant_nxt.
//    Req and grant same cycle -> cnt unchanged. Atom flag FIFO QDEPTH deep, pushed
//    with each req, popped with each grant; head flag = atom of oldest packet.
//  - Eligible(s): cnt>0 and (head atom==0 or cnt>=2). Atomic head waits until
//    its partner is queued.
//  - FSM: IDLE, LOCK.
//    IDLE: if spc_data_rdy_cx and any eligible -> grant first eligible at or after
//      RR pointer (wrapping). Non-atomic win: ptr=winner+1 mod NSRC, stay IDLE.
//      Atomic win: ptr held, go LOCK, lock_src=winner.
//    LOCK: only lock_src may be granted; if spc_data_rdy_cx -> grant lock_src,
//      ptr=lock_src+1 mod NSRC, -> IDLE. If data_rdy low: no grant, stay LOCK.
//  - arb_lock_ca = (state==LOCK), registered with grant_ca.
//  - Latency: req sampled edge N -> earliest grant_ca high cycle N+2 (1 cycle
//    request capture, 1 cycle registered grant). Max 1 grant per cycle.
//  - spc_data_rdy_cx low: no grant, counts only increment.
//  - Overflow: req when cnt==QDEPTH and no same-cycle grant -> q_ovf_err set
//    (sticky until reset), cnt saturates, atom flag dropped.
//  - src_atom_cq without src_req_cq is ignored.
//  - Reset mid-pair (in LOCK) discards all queued state; no partial grant issued.
// CONFIGURATION
//  CPX_ARB_IO_PRIO_EN defined: in IDLE, an eligible IO source (bit NSRC-1) wins
//   over round-robin; RR pointer not updated on IO wins. LOCK rules unchanged
//   (atomic pair from scache is never broken by IO).
//  Undefined: IO participates in round-robin as an ordinary source.
// TESTING
//  1 Reset: arst_l low mid-traffic -> grant_ca=0, arb_lock_ca=0, q_ovf_err=0
//    immediately; after release no grant until new req.
//  2 Single req scache2 at cycle 0, data_rdy=1 -> grant_ca=5'b00100 at cycle 2 only.
//  3 All 5 sources req one packet same cycle, data_rdy=1 -> grants 00001,00010,
//    00100,01000,10000 in consecutive cycles; ptr returns to 0.
//  4 scache1 req+atom cycle 0, scache1 req cycle 3, scache0 req cycle 1 -> scache0
//    granted cycle 3; scache1 granted cycles 5,6 with arb_lock_ca=1 in cycle 6;
//    drop data_rdy during lock -> grant stalls, no other source granted.
//  5 Three reqs from IO with no grants (data_rdy=0), QDEPTH=2 -> q_ovf_err=1 after
//    third; stays 1 after data_rdy=1 drains 2 grants.
//  6 With CPX_ARB_IO_PRIO_EN: scache0..3 and IO req together -> IO granted first
//    (10000), then scache0..3 in order; without macro, IO granted last.

Source files
------------

// File: rtl/cpx_dest_arb.sv
// Per-destination CPX arbiter: per-source packet counts and atom-flag FIFOs,
// round-robin issue with atomic-pair locking. Define CPX_ARB_IO_PRIO_EN to give IO priority in IDLE.
module cpx_dest_arb #(
    parameter int NSRC   = 5,
    parameter int QDEPTH = 2
) (
    input  logic            rclk,
    input  logic            arst_l,
    input  logic [NSRC-1:0] src_req_cq,
    input  logic [NSRC-1:0] src_atom_cq,
    input  logic            spc_data_rdy_cx,
    output logic [NSRC-1:0] grant_ca,
    output logic            arb_lock_ca,
    output logic            q_ovf_err
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_PAIR = CW'(32'd2);
    localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);
    localparam logic [PW-1:0] IDX_LAST = PW'(NSRC - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   lock_src_r;
    logic [CW-1:0]   cnt_r      [NSRC];
    logic [QDEPTH-1:0] atom_r   [NSRC];

    logic [NSRC-1:0] elig_s;
    logic [NSRC-1:0] gnt_s;
    logic [NSRC-1:0] push_s;
    logic [NSRC-1:0] ovf_s;
    logic            win_vld_s;
    logic            win_atom_s;
    logic [PW-1:0]   win_idx_s;
    logic [CW-1:0]   cnt_nxt_s  [NSRC];
    logic [CW-1:0]   wptr_s     [NSRC];
    logic [QDEPTH-1:0] atom_nxt_s [NSRC];

    function automatic logic [PW-1:0] inc_idx(input logic [PW-1:0] idx);
        if (idx == IDX_LAST) begin
            return {PW{1'b0}};
        end else begin
            return idx + PW'(32'd1);
        end
    endfunction

    // An atomic head is only eligible once its partner is queued behind it.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            elig_s[s] = (cnt_r[s] != CNT_ZERO) && (!atom_r[s][0] || (cnt_r[s] >= CNT_PAIR));
        end
    end

    // Winner selection: first eligible at/after ptr, then wrap to the lowest index.
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = {PW{1'b0}};
        case (state_r)
            IDLE: begin
`ifdef CPX_ARB_IO_PRIO_EN
                win_idx_s = (spc_data_rdy_cx && elig_s[NSRC-1]) ? IDX_LAST : win_idx_s;
                win_vld_s = spc_data_rdy_cx && elig_s[NSRC-1];
`endif
                for (int s = 0; s < NSRC; s++) begin
                    win_idx_s = (spc_data_rdy_cx && !win_vld_s && elig_s[s] && (PW'(s) >= ptr_r)) ? PW'(s) : win_idx_s;
                    win_vld_s = win_vld_s | (spc_data_rdy_cx && elig_s[s] && (PW'(s) >= ptr_r));
                end
                for (int s = 0; s < NSRC; s++) begin
                    win_idx_s = (spc_data_rdy_cx && !win_vld_s && elig_s[s]) ? PW'(s) : win_idx_s;
                    win_vld_s = win_vld_s | (spc_data_rdy_cx && elig_s[s]);
                end
            end
            LOCK: begin
                win_vld_s = spc_data_rdy_cx && (cnt_r[lock_src_r] != CNT_ZERO);
                win_idx_s = lock_src_r;
            end
            default: begin
                win_vld_s = 1'b0;
                win_idx_s = {PW{1'b0}};
            end
        endcase
        win_atom_s = atom_r[win_idx_s][0];
    end

    // One-hot grant decoded from the winner.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            gnt_s[s] = win_vld_s && (win_idx_s == PW'(s));
        end
    end

    // Next occupancy and atom FIFO contents; a full queue drops the request unless it pops this cycle.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            push_s[s] = src_req_cq[s] && ((cnt_r[s] != CNT_FULL) || gnt_s[s]);
            ovf_s[s]  = src_req_cq[s] && (cnt_r[s] == CNT_FULL) && !gnt_s[s];
            case ({push_s[s], gnt_s[s]})
                2'b10:   cnt_nxt_s[s] = cnt_r[s] + CNT_ONE;
                2'b01:   cnt_nxt_s[s] = cnt_r[s] - CNT_ONE;
                default: cnt_nxt_s[s] = cnt_r[s];
            endcase
            wptr_s[s]     = gnt_s[s] ? (cnt_r[s] - CNT_ONE) : cnt_r[s];
            atom_nxt_s[s] = gnt_s[s] ? {1'b0, atom_r[s][QDEPTH-1:1]} : atom_r[s];
            for (int j = 0; j < QDEPTH; j++) begin
                atom_nxt_s[s][j] = (push_s[s] && (wptr_s[s] == CW'(j))) ? src_atom_cq[s] : atom_nxt_s[s][j];
            end
        end
    end

    // Per-source queue state and sticky overflow flag.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int s = 0; s < NSRC; s++) begin
                cnt_r[s]  <= CNT_ZERO;
                atom_r[s] <= {QDEPTH{1'b0}};
            end
            q_ovf_err <= 1'b0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                cnt_r[s]  <= cnt_nxt_s[s];
                atom_r[s] <= atom_nxt_s[s];
            end
            q_ovf_err <= q_ovf_err | (|ovf_s);
        end
    end

    // Arbiter FSM with registered grant and lock outputs.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_r     <= IDLE;
            ptr_r       <= {PW{1'b0}};
            lock_src_r  <= {PW{1'b0}};
            grant_ca    <= {NSRC{1'b0}};
            arb_lock_ca <= 1'b0;
        end else begin
            grant_ca    <= gnt_s;
            arb_lock_ca <= (state_r == LOCK);
            case (state_r)
                IDLE: begin
                    if (win_vld_s && win_atom_s) begin
                        state_r    <= LOCK;
                        lock_src_r <= win_idx_s;
                    end else if (win_vld_s) begin
`ifdef CPX_ARB_IO_PRIO_EN
                        ptr_r <= (win_idx_s == IDX_LAST) ? ptr_r : inc_idx(win_idx_s);
`else
                        ptr_r <= inc_idx(win_idx_s);
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOCK: begin
                    if (win_vld_s) begin
                        ptr_r   <= inc_idx(lock_src_r);
                        state_r <= IDLE;
                    end else begin
                        state_r <= LOCK;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
